// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, ALU and response signals for alu_share_arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_share_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int CW    = 3,
    parameter int CNT_W = 16
);
    logic            req0_valid;
    logic            req0_ready;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [CW-1:0]   req0_ctrl;
    logic            req1_valid;
    logic            req1_ready;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [CW-1:0]   req1_ctrl;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [CW-1:0]   alu_ctrl;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic            rsp_valid;
    logic            rsp_id;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_zero;
    logic            rsp_ready;
    logic            busy;
    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl,
        input  req1_valid, req1_a, req1_b, req1_ctrl,
        input  alu_result, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_zero,
        output busy, grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl,
        output req1_valid, req1_a, req1_b, req1_ctrl,
        output alu_result, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero,
        input  busy, grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Define ALU_ARB_STATS_EN to build the saturating grant counters.
module alu_share_arbiter #(
    parameter int XLEN  = 32,
    parameter int CW    = 3,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    alu_share_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]      state_q;
    logic            last_q;
    logic            gnt0;
    logic            gnt1;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [CW-1:0]   ctrl_q;
    logic            vld_q;
    logic            id_q;
    logic [XLEN-1:0] res_q;
    logic            zero_q;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Grant at most one port in IDLE; a tie goes to the port not served last.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (bus.req0_valid && (!bus.req1_valid || last_q))
                gnt0 = 1'b1;
            else if (bus.req1_valid)
                gnt1 = 1'b1;
        end
    end

    // Sequencer: latch operands on grant, capture the ALU, hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            vld_q   <= 1'b0;
            id_q    <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0) begin
                        a_q     <= bus.req0_a;
                        b_q     <= bus.req0_b;
                        ctrl_q  <= bus.req0_ctrl;
                        last_q  <= 1'b0;
                        state_q <= EXEC;
                    end else if (gnt1) begin
                        a_q     <= bus.req1_a;
                        b_q     <= bus.req1_b;
                        ctrl_q  <= bus.req1_ctrl;
                        last_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= bus.alu_result;
                    zero_q  <= bus.alu_zero;
                    id_q    <= last_q;
                    vld_q   <= 1'b1;
                    state_q <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        vld_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_STATS_EN
    // Per-port grant counters that stick at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0 && (cnt0_q != {CNT_W{1'b1}}))
                cnt0_q <= cnt0_q + CNT_W'(1);
            if (gnt1 && (cnt1_q != {CNT_W{1'b1}}))
                cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end
`else
    assign cnt0_q = '0;
    assign cnt1_q = '0;
`endif

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_ctrl   = ctrl_q;
    assign bus.rsp_valid  = vld_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
endmodule
